// File: rtl/burst_xbar_scheduler_pkg.sv
// Shared types and helpers for the burst crossbar scheduler.
// Holds the per-port FSM state encoding and the round-robin pointer wrap.
package burst_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sched_state_t;

    // Next round-robin start position after granting ptr; wraps at n.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/burst_xbar_scheduler_if.sv
// Request and output-port bundle of the burst crossbar scheduler.
// master drives requests and downstream ready; slave is the scheduler.
interface burst_xbar_scheduler_if #(
    parameter int N_IN      = 8,
    parameter int N_OUT     = 8,
    parameter int MAX_BURST = 16
);
    localparam int IW = $clog2(N_IN);
    localparam int OW = $clog2(N_OUT);
    localparam int LW = $clog2(MAX_BURST);

    logic [N_IN-1:0]            in_valid;
    logic [N_IN-1:0]            in_ready;
    logic [N_IN-1:0][OW-1:0]    in_port;
    logic [N_IN-1:0][LW-1:0]    in_len_m1;
    logic [N_IN-1:0]            in_done;
    logic [N_OUT-1:0]           out_valid;
    logic [N_OUT-1:0]           out_ready;
    logic [N_OUT-1:0]           out_last;
    logic [N_OUT-1:0][IW-1:0]   out_src_id;
    logic [N_OUT-1:0][N_IN-1:0] out_sel;

    modport master (
        output in_valid, in_port, in_len_m1, out_ready,
        input  in_ready, in_done, out_valid, out_last,
        input  out_src_id, out_sel
    );

    modport slave (
        input  in_valid, in_port, in_len_m1, out_ready,
        output in_ready, in_done, out_valid, out_last,
        output out_src_id, out_sel
    );

endinterface

// File: rtl/burst_xbar_scheduler_port_sched.sv
// One output port: round-robin pick among eligible requesters, then
// hold the port for the whole burst and count beats until the last one.
module burst_port_sched
    import burst_sched_pkg::*;
#(
    parameter int  N_IN      = 8,
    parameter int  MAX_BURST = 16,
    localparam int IW        = $clog2(N_IN),
    localparam int LW        = $clog2(MAX_BURST)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_IN-1:0]          elig,
    input  logic [N_IN-1:0][LW-1:0]  len_m1,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic                     out_last,
    output logic [IW-1:0]            out_src_id,
    output logic [N_IN-1:0]          out_sel,
    output logic [N_IN-1:0]          fin
);

    sched_state_t    state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   len_q, len_d;
    logic            last_q, last_d;
    logic [IW-1:0]   src_q, src_d;
    logic [N_IN-1:0] sel_q, sel_d;

    logic            found;
    logic [IW-1:0]   win;
    logic            beat;
    int              idx;

    // Round-robin search starting at the priority pointer.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < N_IN; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_IN) idx = idx - N_IN;
            if (!found && elig[IW'(idx)]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    assign beat = (state_q == BUSY) && out_ready;

    // Grant on IDLE, count beats on BUSY, release after the last one.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        last_d  = last_q;
        src_d   = src_q;
        sel_d   = sel_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = BUSY;
                    ptr_d      = IW'(rr_next(int'(win), N_IN));
                    cnt_d      = '0;
                    len_d      = len_m1[win];
                    last_d     = (len_m1[win] == '0);
                    src_d      = win;
                    sel_d      = '0;
                    sel_d[win] = 1'b1;
                end
            end
            BUSY: begin
                if (beat) begin
                    if (last_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        last_d  = 1'b0;
                        src_d   = '0;
                        sel_d   = '0;
                    end else begin
                        cnt_d  = cnt_q + LW'(1);
                        last_d = ((cnt_q + LW'(1)) == len_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and registered port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            last_q  <= 1'b0;
            src_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            last_q  <= last_d;
            src_q   <= src_d;
            sel_q   <= sel_d;
        end
    end

    assign out_valid  = (state_q == BUSY);
    assign out_last   = last_q;
    assign out_src_id = src_q;
    assign out_sel    = sel_q;
    assign fin        = (beat && last_q) ? sel_q : '0;

endmodule

// File: rtl/burst_xbar_scheduler.sv
// Burst crossbar scheduler: one request slot per requester and an
// independent round-robin burst FSM per output port.
module burst_xbar_scheduler
    import burst_sched_pkg::*;
#(
    parameter int  N_IN      = 8,
    parameter int  N_OUT     = 8,
    parameter int  MAX_BURST = 16,
    localparam int IW        = $clog2(N_IN),
    localparam int OW        = $clog2(N_OUT),
    localparam int LW        = $clog2(MAX_BURST)
) (
    input  logic                   clk,
    input  logic                   rst,
    burst_xbar_scheduler_if.slave  bus
);

    logic [N_IN-1:0]            slot_valid_q, slot_valid_d;
    logic [N_IN-1:0][OW-1:0]    port_q, port_d;
    logic [N_IN-1:0][LW-1:0]    len_q, len_d;
    logic [N_IN-1:0]            fin_q, fin_d;
    logic [N_IN-1:0]            done_q, done_d;

    logic [N_IN-1:0]            accept;
    logic [N_IN-1:0]            owned;
    logic [N_IN-1:0][N_OUT-1:0] col;
    logic [N_OUT-1:0][N_IN-1:0] elig;
    logic [N_OUT-1:0][N_IN-1:0] sel_w;
    logic [N_OUT-1:0][N_IN-1:0] fin_w;
    logic [N_OUT-1:0]           valid_w;
    logic [N_OUT-1:0]           last_w;
    logic [N_OUT-1:0][IW-1:0]   src_w;

    // Slot capture/free; a finished burst frees its slot one edge later.
    always_comb begin
        accept       = bus.in_valid & ~slot_valid_q;
        slot_valid_d = (slot_valid_q & ~fin_q) | accept;
        port_d       = port_q;
        len_d        = len_q;
        for (int i = 0; i < N_IN; i++) begin
            if (accept[i]) begin
                port_d[i] = bus.in_port[i];
                len_d[i]  = bus.in_len_m1[i];
            end
        end
        fin_d = '0;
        for (int p = 0; p < N_OUT; p++) fin_d = fin_d | fin_w[p];
        done_d = fin_q;
    end

    // Per-port eligibility: pending, aimed here, not owned, not finishing.
    always_comb begin
        col   = '0;
        owned = '0;
        elig  = '0;
        for (int i = 0; i < N_IN; i++) begin
            for (int p = 0; p < N_OUT; p++) col[i][p] = sel_w[p][i];
            owned[i] = |col[i];
        end
        for (int p = 0; p < N_OUT; p++) begin
            for (int i = 0; i < N_IN; i++) begin
                elig[p][i] = slot_valid_q[i] && !owned[i] && !fin_q[i]
                          && (int'(port_q[i]) == p);
            end
        end
    end

    // Request slots and the delayed done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid_q <= '0;
            port_q       <= '0;
            len_q        <= '0;
            fin_q        <= '0;
            done_q       <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            port_q       <= port_d;
            len_q        <= len_d;
            fin_q        <= fin_d;
            done_q       <= done_d;
        end
    end

    for (genvar p = 0; p < N_OUT; p++) begin : g_port
        burst_port_sched #(
            .N_IN      (N_IN),
            .MAX_BURST (MAX_BURST)
        ) u_sched (
            .clk        (clk),
            .rst        (rst),
            .elig       (elig[p]),
            .len_m1     (len_q),
            .out_ready  (bus.out_ready[p]),
            .out_valid  (valid_w[p]),
            .out_last   (last_w[p]),
            .out_src_id (src_w[p]),
            .out_sel    (sel_w[p]),
            .fin        (fin_w[p])
        );

        a_sel_onehot: assert property (@(posedge clk) disable iff (rst)
            $onehot0(bus.out_sel[p]));
        a_sel_valid: assert property (@(posedge clk) disable iff (rst)
            ((|bus.out_sel[p]) == bus.out_valid[p]));
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_req
        a_port_legal: assert property (@(posedge clk) disable iff (rst)
            bus.in_valid[i] |-> (int'(bus.in_port[i]) < N_OUT));
        a_one_owner: assert property (@(posedge clk) disable iff (rst)
            $onehot0(col[i]));
        // done is raised on the same edge that frees the slot
        a_done_slot: assert property (@(posedge clk) disable iff (rst)
            bus.in_done[i] |-> $past(slot_valid_q[i]));
    end

    assign bus.in_ready   = ~slot_valid_q;
    assign bus.in_done    = done_q;
    assign bus.out_valid  = valid_w;
    assign bus.out_last   = last_w;
    assign bus.out_src_id = src_w;
    assign bus.out_sel    = sel_w;

endmodule

// File: tb/tb_burst_xbar_scheduler.sv
// Bench for burst_xbar_scheduler: an 8-requester and a 6-requester
// instance driven side by side and compared every cycle to a model.
module tb_burst_xbar_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    burst_xbar_scheduler_if #(.N_IN(8), .N_OUT(8), .MAX_BURST(16)) bus8 ();
    burst_xbar_scheduler_if #(.N_IN(6), .N_OUT(8), .MAX_BURST(16)) bus6 ();

    burst_xbar_scheduler #(.N_IN(8), .N_OUT(8), .MAX_BURST(16)) dut8 (
        .clk (clk), .rst (rst), .bus (bus8)
    );
    burst_xbar_scheduler #(.N_IN(6), .N_OUT(8), .MAX_BURST(16)) dut6 (
        .clk (clk), .rst (rst), .bus (bus6)
    );

    logic [7:0] v_valid [2];
    logic [2:0] v_port  [2][8];
    logic [3:0] v_len   [2][8];
    logic [7:0] v_rdy   [2];
    bit   [7:0] hold    [2];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            bus8.in_port[i]   = v_port[0][i];
            bus8.in_len_m1[i] = v_len[0][i];
        end
        for (int i = 0; i < 6; i++) begin
            bus6.in_port[i]   = v_port[1][i];
            bus6.in_len_m1[i] = v_len[1][i];
        end
        bus8.in_valid  = v_valid[0];
        bus6.in_valid  = v_valid[1][5:0];
        bus8.out_ready = v_rdy[0];
        bus6.out_ready = v_rdy[1];
    end

    int n_run  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Model: slot contents, per-port owner / beats done / rr pointer.
    bit [7:0] m_slot [2];
    bit [7:0] m_fin  [2];
    bit [7:0] m_done [2];
    int m_tgt  [2][8];
    int m_blen [2][8];
    int m_own  [2][8];
    int m_got  [2][8];
    int m_ptr  [2][8];

    function automatic int nin(input int d);
        return (d == 0) ? 8 : 6;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_slot[d] = '0;
            m_fin[d]  = '0;
            m_done[d] = '0;
            for (int k = 0; k < 8; k++) begin
                m_tgt[d][k]  = 0;
                m_blen[d][k] = 1;
                m_own[d][k]  = -1;
                m_got[d][k]  = 0;
                m_ptr[d][k]  = 0;
            end
        end
    endtask

    task automatic model_edge(input int d, output bit [7:0] acc);
        int n;
        int i;
        bit [7:0] slot_pre, fin_pre, nfin;
        n        = nin(d);
        slot_pre = m_slot[d];
        fin_pre  = m_fin[d];
        nfin     = '0;
        acc      = '0;
        m_done[d] = fin_pre;
        for (int p = 0; p < 8; p++) begin
            if (m_own[d][p] >= 0) begin
                if (v_rdy[d][p]) begin
                    m_got[d][p]++;
                    if (m_got[d][p] == m_blen[d][m_own[d][p]]) begin
                        nfin[m_own[d][p]] = 1'b1;
                        m_own[d][p] = -1;
                        m_got[d][p] = 0;
                    end
                end
            end else begin
                for (int k = 0; k < n; k++) begin
                    i = (m_ptr[d][p] + k) % n;
                    if (slot_pre[i] && !fin_pre[i] && m_tgt[d][i] == p) begin
                        m_own[d][p] = i;
                        m_got[d][p] = 0;
                        m_ptr[d][p] = (i + 1) % n;
                        break;
                    end
                end
            end
        end
        for (int k = 0; k < n; k++) begin
            if (v_valid[d][k] && !slot_pre[k]) begin
                acc[k]       = 1'b1;
                m_tgt[d][k]  = int'(v_port[d][k]);
                m_blen[d][k] = int'(v_len[d][k]) + 1;
            end
        end
        m_slot[d] = (slot_pre & ~fin_pre) | acc;
        m_fin[d]  = nfin;
    endtask

    task automatic compare(input int d);
        logic [7:0]  e_rdy, e_done, e_vld, e_lst;
        logic [7:0]  o_rdy, o_done, o_vld, o_lst;
        logic [23:0] e_src, o_src;
        logic [63:0] e_sel, o_sel;
        string s;
        int n;
        n = nin(d);
        e_rdy = '0; e_done = '0; e_vld = '0; e_lst = '0;
        e_src = '0; e_sel = '0;
        for (int i = 0; i < n; i++) begin
            e_rdy[i]  = !m_slot[d][i];
            e_done[i] = m_done[d][i];
        end
        for (int p = 0; p < 8; p++) begin
            if (m_own[d][p] >= 0) begin
                e_vld[p] = 1'b1;
                e_lst[p] = (m_got[d][p] == m_blen[d][m_own[d][p]] - 1);
                e_src[p*3 +: 3] = 3'(m_own[d][p]);
                e_sel[p*n + m_own[d][p]] = 1'b1;
            end
        end
        if (d == 0) begin
            s = "n8"; o_rdy = bus8.in_ready; o_done = bus8.in_done;
            o_vld = bus8.out_valid; o_lst = bus8.out_last;
            o_src = bus8.out_src_id; o_sel = 64'(bus8.out_sel);
        end else begin
            s = "n6"; o_rdy = 8'(bus6.in_ready); o_done = 8'(bus6.in_done);
            o_vld = bus6.out_valid; o_lst = bus6.out_last;
            o_src = bus6.out_src_id; o_sel = 64'(bus6.out_sel);
        end
        check_eq({s, ".in_ready"},   64'(o_rdy),  64'(e_rdy));
        check_eq({s, ".in_done"},    64'(o_done), 64'(e_done));
        check_eq({s, ".out_valid"},  64'(o_vld),  64'(e_vld));
        check_eq({s, ".out_last"},   64'(o_lst),  64'(e_lst));
        check_eq({s, ".out_src_id"}, 64'(o_src),  64'(e_src));
        check_eq({s, ".out_sel"},    o_sel,       e_sel);
    endtask

    task automatic cycle();
        bit [7:0] acc;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            model_edge(d, acc);
            for (int i = 0; i < 8; i++)
                if (acc[i] && !hold[d][i]) v_valid[d][i] = 1'b0;
            compare(d);
        end
    endtask

    task automatic run(input int c);
        repeat (c) cycle();
    endtask

    task automatic req(input int i, input int p, input int len, input bit hld);
        for (int d = 0; d < 2; d++) begin
            if (i < nin(d)) begin
                v_valid[d][i] = 1'b1;
                v_port[d][i]  = 3'(p);
                v_len[d][i]   = 4'(len);
                hold[d][i]    = hld;
            end
        end
    endtask

    task automatic clear_req();
        for (int d = 0; d < 2; d++) begin
            v_valid[d] = '0;
            hold[d]    = '0;
        end
    endtask

    task automatic set_rdy(input logic [7:0] r);
        v_rdy[0] = r;
        v_rdy[1] = r;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare(0);
        compare(1);
        @(posedge clk);
        #1;
        compare(0);
        compare(1);
        rst = 1'b0;
    endtask

    initial begin
        bit [6:0] bp;
        for (int d = 0; d < 2; d++) begin
            v_valid[d] = '0;
            v_rdy[d]   = '1;
            hold[d]    = '0;
            for (int i = 0; i < 8; i++) begin
                v_port[d][i] = '0;
                v_len[d][i]  = '0;
            end
        end
        #1;
        do_reset();

        // single 3-beat burst: requester 3 -> port 5
        req(3, 5, 2, 1'b0);
        run(8);

        // contention on port 1, continuous re-request
        req(0, 1, 0, 1'b1);
        req(2, 1, 0, 1'b1);
        req(5, 1, 0, 1'b1);
        run(18);
        clear_req();
        run(8);

        // pointer wrap past the top requester
        req(5, 0, 0, 1'b1);
        req(0, 0, 0, 1'b1);
        run(12);
        clear_req();
        run(6);

        // backpressure on a 4-beat burst
        req(1, 2, 3, 1'b0);
        run(2);
        bp = 7'b1011001;
        for (int k = 6; k >= 0; k--) begin
            set_rdy(bp[k] ? 8'hff : 8'hfb);
            cycle();
        end
        set_rdy(8'hff);
        run(4);

        // parallel grants on ports 0 and 7
        req(1, 0, 5, 1'b0);
        req(4, 7, 5, 1'b0);
        run(10);

        // reset in the middle of an 8-beat burst
        req(2, 3, 7, 1'b0);
        run(4);
        #3;
        clear_req();
        do_reset();
        req(1, 3, 1, 1'b0);
        req(4, 3, 1, 1'b0);
        run(12);

        // randomized traffic with random backpressure
        for (int c = 0; c < 1500; c++) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < nin(d); i++) begin
                    if (!v_valid[d][i] && $urandom_range(0, 3) == 0) begin
                        v_valid[d][i] = 1'b1;
                        v_port[d][i]  = 3'($urandom_range(0, 7));
                        v_len[d][i]   = ($urandom_range(0, 7) == 0) ? 4'd15
                                      : 4'($urandom_range(0, 3));
                    end
                end
                for (int p = 0; p < 8; p++)
                    v_rdy[d][p] = ($urandom_range(0, 3) != 0);
            end
            cycle();
        end
        clear_req();
        set_rdy(8'hff);
        run(150);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
